// File: rtl/branch_predictor_gshare.sv
// Gshare conditional-branch predictor: PC/GHR-indexed table of 2-bit counters with
// zero-latency prediction in ID, training and history repair at MEM resolve.
module branch_predictor_gshare #(
    parameter int unsigned GHR_W    = 4,
    parameter int unsigned PC_LSB   = 2,
    parameter logic [1:0]  CTR_INIT = 2'b01,
    parameter int unsigned STAT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc,
    input  logic              id_advance,
    input  logic              jump_early,
    input  logic              branch_early,
    input  logic [31:0]       immID,
    input  logic              branch_resolved,
    input  logic              actual_taken,
    input  logic              mispredict,
    input  logic [GHR_W-1:0]  pht_indexMEM,
    input  logic [GHR_W-1:0]  ghr_MEM,
    output logic [31:0]       PC_Jump,
    output logic [1:0]        flush,
    output logic              jump_taken,
    output logic              predict_taken,
    output logic [GHR_W-1:0]  pht_index,
    output logic [GHR_W-1:0]  ghr_snapshot,
    output logic [31:0]       PC_saved,
    output logic [STAT_W-1:0] branch_count,
    output logic [STAT_W-1:0] mispredict_count
);

    localparam int unsigned     PHT_N    = 1 << GHR_W;
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    logic [GHR_W-1:0]  r_ghr;
    logic [1:0]        r_pht [PHT_N];
    logic [STAT_W-1:0] r_branch_count;
    logic [STAT_W-1:0] r_mispredict_count;

    logic [GHR_W-1:0]  w_index;
    logic [1:0]        w_ctr_id;
    logic [1:0]        w_ctr_mem;
    logic [1:0]        w_ctr_mem_nxt;
    logic              w_predict;
    logic              w_jump;
    logic              w_recover;

    // Prediction path: reads the pre-update counter, so a same-index resolve is not bypassed
    assign w_index   = pc[PC_LSB +: GHR_W] ^ r_ghr;
    assign w_ctr_id  = r_pht[w_index];
    assign w_predict = branch_early & w_ctr_id[1];
    assign w_jump    = jump_early | w_predict;
    assign w_recover = branch_resolved & mispredict;

    assign pht_index        = w_index;
    assign predict_taken    = w_predict;
    assign jump_taken       = w_jump;
    assign flush            = w_jump ? 2'b01 : 2'b00;
    assign PC_Jump          = w_jump ? immID : 32'h0;
    assign ghr_snapshot     = r_ghr;
    assign PC_saved         = pc;
    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

    // Saturating 2-bit counter step for the resolving entry
    assign w_ctr_mem = r_pht[pht_indexMEM];
    always_comb begin
        w_ctr_mem_nxt = w_ctr_mem;
        if (actual_taken) begin
            if (w_ctr_mem != 2'b11) w_ctr_mem_nxt = w_ctr_mem + 2'd1;
        end else begin
            if (w_ctr_mem != 2'b00) w_ctr_mem_nxt = w_ctr_mem - 2'd1;
        end
    end

    // Speculative history: mispredict repair overrides the shift of a flushed ID branch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (w_recover) begin
            r_ghr <= GHR_W'({ghr_MEM, actual_taken});
        end else if (branch_early && id_advance) begin
            r_ghr <= GHR_W'({r_ghr, w_predict});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(PHT_N); i++) begin
                r_pht[i] <= CTR_INIT;
            end
        end else if (branch_resolved) begin
            r_pht[pht_indexMEM] <= w_ctr_mem_nxt;
        end
    end

    // Statistics, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (branch_resolved) begin
            if (r_branch_count != '1) r_branch_count <= r_branch_count + STAT_ONE;
            if (mispredict && (r_mispredict_count != '1)) begin
                r_mispredict_count <= r_mispredict_count + STAT_ONE;
            end
        end
    end

endmodule

// File: doc/branch_predictor_gshare.md
BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

Interface
REQ-001 SHALL have parameter GHR_W, default 4: global history width; the PHT has 2^GHR_W entries.
REQ-002 SHALL have parameter PC_LSB, default 2: lowest PC bit used in the index (word-aligned PCs).
REQ-003 SHALL have parameter CTR_INIT, default 2'b01: counter value after reset (weakly not-taken).
REQ-004 SHALL have parameter STAT_W, default 32: width of the statistics counters.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port pc, input, 32 bits: PC of the instruction currently in ID.
REQ-008 SHALL have port id_advance, input, 1 bit: the ID instruction moves to EX this cycle (not stalled).
REQ-009 SHALL have port jump_early, input, 1 bit: ID holds an unconditional jump.
REQ-010 SHALL have port branch_early, input, 1 bit: ID holds a conditional branch.
REQ-011 SHALL have port immID, input, 32 bits: target computed in ID.
REQ-012 SHALL have port branch_resolved, input, 1 bit: a branch resolves in MEM this cycle.
REQ-013 SHALL have port actual_taken, input, 1 bit: resolved outcome.
REQ-014 SHALL have port mispredict, input, 1 bit: the resolved outcome differs from the prediction; valid only with branch_resolved.
REQ-015 SHALL have port pht_indexMEM, input, GHR_W bits: index carried down the pipe for the resolving branch.
REQ-016 SHALL have port ghr_MEM, input, GHR_W bits: GHR checkpoint carried with the resolving branch.
REQ-017 SHALL have port PC_Jump, output, 32 bits: redirect target.
REQ-018 SHALL have port flush, output, 2 bits: pipeline flush code.
REQ-019 SHALL have port jump_taken, output, 1 bit: redirect asserted.
REQ-020 SHALL have port predict_taken, output, 1 bit: conditional-branch prediction.
REQ-021 SHALL have port pht_index, output, GHR_W bits: index used for the ID branch.
REQ-022 SHALL have port ghr_snapshot, output, GHR_W bits: speculative GHR before the ID branch's shift.
REQ-023 SHALL have port PC_saved, output, 32 bits: equal to pc.
REQ-024 SHALL have ports branch_count and mispredict_count, output, STAT_W bits each: statistics counters.

Function
REQ-025 pht_index SHALL equal pc[PC_LSB+GHR_W-1:PC_LSB] XOR spec_GHR, combinationally.
REQ-026 predict_taken SHALL equal branch_early AND PHT[pht_index][1].
REQ-027 jump_taken SHALL equal jump_early OR predict_taken.
REQ-028 flush SHALL be 2'b01 when jump_taken is high, else 2'b00.
REQ-029 PC_Jump SHALL be immID when jump_taken is high, else 32'h0.
REQ-030 spec_GHR SHALL shift left by one, inserting predict_taken, on each cycle with branch_early and id_advance both high; a stalled branch SHALL shift exactly once, on the cycle it advances.
REQ-031 On branch_resolved, PHT[pht_indexMEM] SHALL update as a 2-bit saturating counter: +1 if taken (saturate at 3), -1 if not taken (saturate at 0).
REQ-032 On branch_resolved with mispredict, spec_GHR SHALL be loaded with {ghr_MEM[GHR_W-2:0], actual_taken} next cycle.
REQ-033 On simultaneous mispredict recovery and a REQ-030 shift, the recovery SHALL win and the shift SHALL be discarded (the ID instruction is flushed).
REQ-034 When pht_indexMEM equals pht_index in the same cycle, prediction SHALL use the pre-update counter value (no bypass).
REQ-035 branch_count SHALL increment on each branch_resolved; mispredict_count SHALL increment on each branch_resolved with mispredict; both SHALL saturate at all-ones.
REQ-036 Outputs other than the counters SHALL be combinational from inputs and state; prediction latency is 0 cycles and PHT/GHR update latency is 1 cycle.

Reset
REQ-037 While rst is high at a clock edge, spec_GHR SHALL become 0, every PHT entry SHALL become CTR_INIT, and both counters SHALL become 0.
REQ-038 While rst is high, resolve and advance inputs SHALL be ignored; rst SHALL take priority over all simultaneous updates.

Verification
REQ-039 Post-reset branch at pc=0x10 with id_advance=1 -> pht_index=4, predict_taken=0, flush=00, spec_GHR=0000 next cycle.
REQ-040 Two taken resolves at index 4 with rst low, then branch at pc=0x10 with GHR=0 -> predict_taken=1, PC_Jump=immID, flush=01.
REQ-041 Four taken resolves on one index -> counter holds at 3; five not-taken resolves -> counter holds at 0.
REQ-042 Speculative GHR=1011 with mispredict, ghr_MEM=0010, actual_taken=1, branch_early and id_advance high in the same cycle -> GHR=0101 next cycle.
REQ-043 branch_early held 3 cycles with id_advance low for 2, then high -> exactly one GHR shift.
REQ-044 Counters preloaded near all-ones with STAT_W=4 -> saturate at 15; rst mid-sequence -> all state cleared on the next edge.
